// File: rtl/weight_stream_scheduler.sv
// Streams a 2-cycle-latency parameter ROM to a valid/ready consumer, replaying it
// repeat_count times per start; a credit check keeps the small output FIFO from overflowing.
module weight_stream_scheduler #(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 576,
    parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [REPEAT_WIDTH-1:0] repeat_count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic                    rom_ce,
    input  logic [DATA_WIDTH-1:0]   rom_q,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_out_valid,
    input  logic                    data_out_ready,
    output logic                    data_out_last,
    output logic                    data_out_final
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = PTR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [REPEAT_WIDTH-1:0] pass_reg, pass_next;
    logic [REPEAT_WIDTH-1:0] rep_max_reg, rep_max_next;
    logic                    done_reg, done_next;

    logic s1_valid_reg, s1_last_reg, s1_final_reg;
    logic s2_valid_reg, s2_last_reg, s2_final_reg;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] fifo_count_reg, fifo_count_next;

    logic [DATA_WIDTH-1:0] entry_data  [FIFO_DEPTH];
    logic                  entry_last  [FIFO_DEPTH];
    logic                  entry_final [FIFO_DEPTH];

    logic              addr_is_last, pass_is_last, issue, push, pop;
    logic [CRED_W-1:0] credit_used;

    assign addr_is_last = (addr_reg == ADDR_WIDTH'(DEPTH - 1));
    assign pass_is_last = (pass_reg == rep_max_reg);
    // Words already queued plus words still inside the ROM pipeline each hold a slot.
    assign credit_used  = CRED_W'(fifo_count_reg) + CRED_W'(s1_valid_reg) + CRED_W'(s2_valid_reg);
    assign issue        = (state_reg == S_RUN) && (credit_used < CRED_W'(FIFO_DEPTH));
    assign push         = s2_valid_reg;
    assign pop          = data_out_valid && data_out_ready;

    assign data_out_valid = (fifo_count_reg != '0);
    assign data_out       = entry_data[rd_ptr_reg];
    assign data_out_last  = data_out_valid && entry_last[rd_ptr_reg];
    assign data_out_final = data_out_valid && entry_final[rd_ptr_reg];

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign rom_addr = addr_reg;
    assign rom_ce   = rst;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        pass_next    = pass_reg;
        rep_max_next = rep_max_reg;
        done_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_RUN;
                    addr_next    = '0;
                    pass_next    = '0;
                    rep_max_next = (repeat_count == '0) ? '0 : repeat_count - REPEAT_WIDTH'(1);
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (addr_is_last) begin
                        addr_next = '0;
                        pass_next = pass_reg + REPEAT_WIDTH'(1);
                        if (pass_is_last) begin
                            state_next = S_DRAIN;
                        end
                    end else begin
                        addr_next = addr_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && data_out_final && fifo_count_reg == CNT_W'(1)
                    && !s1_valid_reg && !s2_valid_reg) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count_reg + CNT_W'(1);
            2'b01:   fifo_count_next = fifo_count_reg - CNT_W'(1);
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            pass_reg       <= '0;
            rep_max_reg    <= '0;
            done_reg       <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_last_reg    <= 1'b0;
            s1_final_reg   <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_last_reg    <= 1'b0;
            s2_final_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            pass_reg       <= pass_next;
            rep_max_reg    <= rep_max_next;
            done_reg       <= done_next;
            // Tags travel alongside the fixed-latency ROM pipeline.
            s1_valid_reg   <= issue;
            s1_last_reg    <= issue && addr_is_last;
            s1_final_reg   <= issue && addr_is_last && pass_is_last;
            s2_valid_reg   <= s1_valid_reg;
            s2_last_reg    <= s1_last_reg;
            s2_final_reg   <= s1_final_reg;
            fifo_count_reg <= fifo_count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] data_reg;
            logic                  last_reg;
            logic                  final_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg  <= '0;
                    last_reg  <= 1'b0;
                    final_reg <= 1'b0;
                end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
                    data_reg  <= rom_q;
                    last_reg  <= s2_last_reg;
                    final_reg <= s2_final_reg;
                end
            end

            assign entry_data[gi]  = data_reg;
            assign entry_last[gi]  = last_reg;
            assign entry_final[gi] = final_reg;
        end
    endgenerate

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_count_reg == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Directed bench for weight_stream_scheduler with a small 8-word ROM model.
module tb_weight_stream_scheduler;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH) + 1;
    localparam int FD    = 4;
    localparam int RW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] repeat_count = '0;
    logic          busy, done;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q = '0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic          data_out_last, data_out_final;

    int num_cmp = 0;
    int num_err = 0;

    weight_stream_scheduler #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .FIFO_DEPTH(FD), .REPEAT_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .repeat_count(repeat_count),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce),
        .rom_q(rom_q), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last),
        .data_out_final(data_out_final)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Two-stage ROM: address registered, then data registered.
    logic [AW-1:0] rom_a1 = '0;
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_a1 <= rom_addr;
            rom_q  <= rom_word(int'(rom_a1));
        end
    end

    // Runs one job from the current negedge; returns at the negedge where done is seen.
    task automatic run_stream(input string name, input int rep, input int nbeats,
                              input int ready_pct, input bit exact_timing, input int restart_k);
        int  n;
        int  last_hs_k;
        bit  got_done;
        bit  prev_stall;
        bit  exp_v;
        repeat_count = RW'(rep);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat_count = RW'(6);
        n = 0;
        last_hs_k = -1;
        got_done = 1'b0;
        prev_stall = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k == restart_k) begin
                start = 1'b1;
                repeat_count = RW'(5);
            end else begin
                start = 1'b0;
            end
            data_out_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
            if (done) begin
                got_done = 1'b1;
                num_cmp++;
                if (n !== nbeats || last_hs_k !== k - 1 || busy !== 1'b0) begin
                    num_err++;
                    $display("FAIL %s done: beats=%0d final_hs_cycle=%0d busy=%b at cycle %0d, required beats=%0d hs_cycle=%0d busy=0",
                             name, n, last_hs_k, busy, k, nbeats, k - 1);
                end
                start = 1'b0;
                break;
            end
            num_cmp++;
            if (busy !== 1'b1) begin
                num_err++;
                $display("FAIL %s busy at cycle %0d: got %b required 1", name, k, busy);
            end
            if (exact_timing) begin
                exp_v = (k >= 3) && (k < 3 + nbeats);
                num_cmp++;
                if (data_out_valid !== exp_v) begin
                    num_err++;
                    $display("FAIL %s valid at cycle %0d: got %b required %b", name, k, data_out_valid, exp_v);
                end
            end
            if (prev_stall) begin
                num_cmp++;
                if (data_out_valid !== 1'b1) begin
                    num_err++;
                    $display("FAIL %s valid dropped under stall at cycle %0d: got 0 required 1", name, k);
                end
            end
            num_cmp++;
            if (dut.fifo_count_reg > FD) begin
                num_err++;
                $display("FAIL %s fifo occupancy at cycle %0d: got %0d required <= %0d", name, k, dut.fifo_count_reg, FD);
            end
            if (data_out_valid) begin
                num_cmp++;
                if (n >= nbeats) begin
                    num_err++;
                    $display("FAIL %s extra beat %0d: got data=%h required no beat", name, n, data_out);
                end else if (data_out !== rom_word(n % DEPTH) || data_out_last !== (n % DEPTH == DEPTH - 1)
                             || data_out_final !== (n == nbeats - 1)) begin
                    num_err++;
                    $display("FAIL %s beat %0d: got data=%h last=%b final=%b required data=%h last=%b final=%b",
                             name, n, data_out, data_out_last, data_out_final,
                             rom_word(n % DEPTH), (n % DEPTH == DEPTH - 1), (n == nbeats - 1));
                end
                if (data_out_ready) begin
                    $display("%s beat %0d cycle %0d data=%h last=%b final=%b",
                             name, n, k, data_out, data_out_last, data_out_final);
                    last_hs_k = k;
                    n++;
                end
            end
            prev_stall = data_out_valid && !data_out_ready;
            @(negedge clk);
        end
        if (!got_done) begin
            num_cmp++;
            num_err++;
            $display("FAIL %s timeout: got %0d beats without done, required %0d beats then done", name, n, nbeats);
        end
    endtask

    task automatic test_reset();
        #1;
        num_cmp++;
        if ({busy, done, data_out_valid, data_out_last, data_out_final, rom_ce} !== 6'b0
            || rom_addr !== '0 || data_out !== '0) begin
            num_err++;
            $display("FAIL reset_values: got busy=%b done=%b valid=%b last=%b final=%b ce=%b addr=%h data=%h required all zero",
                     busy, done, data_out_valid, data_out_last, data_out_final, rom_ce, rom_addr, data_out);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        num_cmp++;
        if (rom_ce !== 1'b1 || busy !== 1'b0) begin
            num_err++;
            $display("FAIL reset_release: got ce=%b busy=%b required ce=1 busy=0", rom_ce, busy);
        end
        @(negedge clk);
        $display("reset sequence complete");
    endtask

    task automatic test_single_pass();
        run_stream("single_pass", 1, DEPTH, 100, 1'b1, -1);
    endtask

    task automatic test_multi_pass();
        run_stream("multi_pass", 3, 3 * DEPTH, 100, 1'b1, -1);
    endtask

    task automatic test_random_ready();
        run_stream("random_ready", 2, 2 * DEPTH, 50, 1'b0, -1);
    endtask

    task automatic test_repeat_zero();
        run_stream("repeat_zero", 0, DEPTH, 100, 1'b1, -1);
    endtask

    task automatic test_start_ignored();
        run_stream("start_ignored", 2, 2 * DEPTH, 100, 1'b1, 5);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b_first", 1, DEPTH, 100, 1'b1, -1);
        run_stream("b2b_second", 1, DEPTH, 100, 1'b1, -1);
    endtask

    task automatic test_reset_mid_job();
        repeat_count = RW'(2);
        data_out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        num_cmp++;
        if ({busy, done, data_out_valid, data_out_last, data_out_final, rom_ce} !== 6'b0
            || rom_addr !== '0 || data_out !== '0) begin
            num_err++;
            $display("FAIL mid_job_reset: got busy=%b done=%b valid=%b last=%b final=%b ce=%b addr=%h data=%h required all zero",
                     busy, done, data_out_valid, data_out_last, data_out_final, rom_ce, rom_addr, data_out);
        end
        $display("mid-job reset applied");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_stream("post_reset", 1, DEPTH, 100, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_random_ready();
        test_repeat_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
        $finish;
    end

endmodule
